// File: rtl/kal_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kal_tx_pkg
// Description : Shared constants for the Kalman estimate UART frame
//               transmitter: header byte, state encoding, frame lengths,
//               minimum baud divider and a byte-fold XOR helper.
// Revision    : 1.0 - initial release
// ============================================================================
package kal_tx_pkg;

  // Both header bytes carry this value
  localparam logic [7:0] HDR_BYTE = 8'hC0;

  // State encoding shared by the framer and the byte engine
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Frame lengths in bytes, with and without the covariance word
  localparam int FRAME_LEN_PCOV = 11;
  localparam int FRAME_LEN_BASE = 7;

  // Smallest bit period minus one the line is ever run at
  localparam int MIN_DIV = 3;

  // XOR of the four bytes of a 32-bit word
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/kal_frame_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 serialiser for a single byte. A start pulse loads the
//               byte and the divider; o_done marks the final clock of the
//               stop bit so the next byte may start with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx #(
  parameter int BAUD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_data,
  input  logic [BAUD_W-1:0] i_div,
  output logic              o_tx,
  output logic              o_done
);
  import kal_tx_pkg::*;

  logic [2:0]        r_state;
  logic [BAUD_W-1:0] r_cnt;
  logic [BAUD_W-1:0] r_div;
  logic [2:0]        r_bit;
  logic [7:0]        r_sh;
  logic              r_tx;
  logic              w_tick;

  assign w_tick = (r_cnt == r_div);
  assign o_done = (r_state == ST_STOP) && w_tick;
  assign o_tx   = r_tx;

  // Bit-level sequencer: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_bit   <= 3'd0;
      r_sh    <= 8'd0;
      r_tx    <= 1'b1;
    end else if (i_start) begin
      // A start may land on the last stop-bit clock: back-to-back bytes
      r_state <= ST_START;
      r_cnt   <= '0;
      r_div   <= i_div;
      r_bit   <= 3'd0;
      r_sh    <= i_data;
      r_tx    <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_sh[0];
          end else begin
            r_cnt <= r_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_sh  <= r_sh >> 1;
              r_tx  <= r_sh[1];
            end
          end else begin
            r_cnt <= r_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + BAUD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/kal_frame_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : kal_frame_uart_tx
// Description : Snapshots Kalman estimate x (and optionally covariance p)
//               and, on trigger, sends a framed XOR-checksummed byte stream
//               over an 8N1 UART line.
//               Build option KAL_TX_PCOV_EN: include p in the frame
//               (11 bytes); otherwise the frame is 7 bytes and i_p is unused.
// Revision    : 1.0 - initial release
// ============================================================================
module kal_frame_uart_tx #(
  parameter int BAUD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_x,
  input  logic [31:0]       i_p,
  input  logic              i_valid,
  input  logic              i_trig,
  input  logic [BAUD_W-1:0] i_baud_div,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_drop
);
  import kal_tx_pkg::*;

`ifdef KAL_TX_PCOV_EN
  localparam int c_frame_len = FRAME_LEN_PCOV;
`else
  localparam int c_frame_len = FRAME_LEN_BASE;
`endif
  localparam logic [3:0] c_last_idx = 4'(c_frame_len - 1);

  // Framer state: IDLE -> LOAD -> DATA (bytes streaming) -> IDLE
  logic [2:0]        r_state;
  logic [3:0]        r_idx;
  logic [BAUD_W-1:0] r_div;
  logic              r_drop;
  logic [31:0]       r_x_s;
  logic [31:0]       r_frm_x;
  logic [31:0]       w_x_fwd;
  logic [7:0]        w_csum;
  logic [7:0]        w_byte;
  logic [3:0]        w_sel_idx;
  logic [BAUD_W-1:0] w_div_eff;
  logic [BAUD_W-1:0] w_div_sel;
  logic              w_start;
  logic              w_done;

  // A valid arriving in the LOAD cycle still reaches the frame copy
  assign w_x_fwd = i_valid ? i_x : r_x_s;

  // Latest x estimate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_x_s <= 32'd0;
    else if (i_valid) r_x_s <= i_x;
  end

`ifdef KAL_TX_PCOV_EN
  logic [31:0] r_p_s;
  logic [31:0] r_frm_p;
  logic [31:0] w_p_fwd;

  assign w_p_fwd = i_valid ? i_p : r_p_s;

  // Latest p estimate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_p_s <= 32'd0;
    else if (i_valid) r_p_s <= i_p;
  end

  // Frame copy of p, frozen for the whole frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_frm_p <= 32'd0;
    else if (r_state == ST_LOAD) r_frm_p <= w_p_fwd;
  end

  assign w_csum = xor_bytes(r_frm_x) ^ xor_bytes(r_frm_p);
`else
  logic w_unused_p;
  assign w_unused_p = ^i_p;
  assign w_csum     = xor_bytes(r_frm_x);
`endif

  // The divider is clamped once per frame; later changes wait for the next
  assign w_div_eff = (i_baud_div < BAUD_W'(MIN_DIV)) ? BAUD_W'(MIN_DIV) : i_baud_div;
  assign w_div_sel = (r_state == ST_LOAD) ? w_div_eff : r_div;

  // LOAD kicks off byte 0 (a header, independent of the frame copy);
  // each done kicks off the following byte on the same clock
  assign w_sel_idx = (r_state == ST_LOAD) ? 4'd0 : (r_idx + 4'd1);
  assign w_start   = (r_state == ST_LOAD) ||
                     ((r_state == ST_DATA) && w_done && (r_idx != c_last_idx));

  // Byte to hand to the serialiser for the selected frame position
  always_comb begin
    w_byte = w_csum;
    case (w_sel_idx)
      4'd0, 4'd1: w_byte = HDR_BYTE;
      4'd2:       w_byte = r_frm_x[31:24];
      4'd3:       w_byte = r_frm_x[23:16];
      4'd4:       w_byte = r_frm_x[15:8];
      4'd5:       w_byte = r_frm_x[7:0];
`ifdef KAL_TX_PCOV_EN
      4'd6:       w_byte = r_frm_p[31:24];
      4'd7:       w_byte = r_frm_p[23:16];
      4'd8:       w_byte = r_frm_p[15:8];
      4'd9:       w_byte = r_frm_p[7:0];
`endif
      default:    w_byte = w_csum;
    endcase
  end

  // Frame sequencer: latch the frame copy, then walk the byte index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_div   <= '0;
      r_frm_x <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_trig) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_frm_x <= w_x_fwd;
          r_div   <= w_div_eff;
          r_idx   <= 4'd0;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_done) begin
            if (r_idx == c_last_idx) r_state <= ST_IDLE;
            else                     r_idx   <= r_idx + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Flag triggers that arrive while a frame is in progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_drop <= 1'b0;
    else          r_drop <= i_trig && (r_state != ST_IDLE);
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_drop = r_drop;

  uart_byte_tx #(
    .BAUD_W (BAUD_W)
  ) u_byte (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_data  (w_byte),
    .i_div   (w_div_sel),
    .o_tx    (o_tx),
    .o_done  (w_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_kal_frame_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_kal_frame_uart_tx
// Description : Self-checking bench for kal_frame_uart_tx. Expected bytes
//               are queued at trigger time from a frame model; a UART
//               receiver monitor decodes o_tx and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kal_frame_uart_tx;

`ifdef KAL_TX_PCOV_EN
  localparam int NB = 11;
`else
  localparam int NB = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_x, i_p;
  logic        i_valid, i_trig;
  logic [15:0] i_baud_div;
  logic        o_tx, o_busy, o_drop;

  always #5 clk = ~clk;

  kal_frame_uart_tx #(.BAUD_W(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_x        (i_x),
    .i_p        (i_p),
    .i_valid    (i_valid),
    .i_trig     (i_trig),
    .i_baud_div (i_baud_div),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_drop     (o_drop)
  );

  typedef struct {
    logic [7:0] b;
    int         per;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mx = 32'd0;
  logic [31:0] mp = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: two headers, x MSB first, optional p, XOR of payload
  function automatic void push_frame(input logic [31:0] x, input logic [31:0] p, input int per);
    logic [7:0] pl[$];
    logic [7:0] cs;
    exp_t       e;
    cs = 8'd0;
    for (int i = 0; i < 4; i++) pl.push_back(8'((x >> (24 - 8 * i)) & 32'hFF));
    if (NB == 11)
      for (int i = 0; i < 4; i++) pl.push_back(8'((p >> (24 - 8 * i)) & 32'hFF));
    e.per = per;
    e.b = 8'hC0;
    sbq.push_back(e);
    sbq.push_back(e);
    foreach (pl[i]) begin
      cs ^= pl[i];
      e.b = pl[i];
      sbq.push_back(e);
    end
    e.b = cs;
    sbq.push_back(e);
  endfunction

  // Receiver monitor: finds the falling start edge, samples mid-bit
  logic       m_act = 1'b0;
  logic       m_prev = 1'b1;
  logic       m_has = 1'b0;
  int         m_cnt = 0;
  int         m_per = 4;
  logic [7:0] m_exp = 8'd0;
  logic [7:0] m_rx = 8'd0;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      m_prev = 1'b1;
    end else begin
      if (!m_act) begin
        if (m_prev && !o_tx) begin
          m_act = 1'b1;
          m_cnt = 0;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got start bit expected idle line at %0t", $time);
            m_has = 1'b0;
            m_per = 4;
          end else begin
            m_e   = sbq.pop_front();
            m_exp = m_e.b;
            m_per = m_e.per;
            m_has = 1'b1;
          end
        end
      end else begin
        m_cnt++;
      end
      if (m_act && (m_cnt % m_per) == (m_per / 2)) begin
        if (m_cnt / m_per == 0) chk("start_bit_low", o_tx, 0);
        else if (m_cnt / m_per <= 8) m_rx[m_cnt / m_per - 1] = o_tx;
        else begin
          chk("stop_bit_high", o_tx, 1);
          if (m_has) chk("rx_byte", m_rx, m_exp);
          m_act = 1'b0;
        end
      end
      m_prev = o_tx;
    end
  end

  task automatic pulse_valid(input logic [31:0] x, input logic [31:0] p);
    @(posedge clk); #1;
    i_valid = 1'b1; i_x = x; i_p = p; mx = x; mp = p;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // act: 0 none, 1 divider change, 2 extra trigger, 3 valid mid-frame, 4 reset
  task automatic run_frame(input bit b2b, input bit do_valid, input logic [31:0] x,
                           input logic [31:0] p, input int act, input int act_cyc);
    int per, cnt, drops, exp_drops;
    bit done, drop_chk;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    if (do_valid) begin
      i_valid = 1'b1; i_x = x; i_p = p; mx = x; mp = p;
    end
    i_trig = 1'b1;
    per = ((i_baud_div < 16'd3) ? 3 : int'(i_baud_div)) + 1;
    push_frame(mx, mp, per);
    @(posedge clk); #1;
    i_trig = 1'b0; i_valid = 1'b0;
    chk("busy_in_load", o_busy, 1);
    chk("tx_idle_in_load", o_tx, 1);
    @(posedge clk); #1;
    chk("start_bit_at_T2", o_tx, 0);
    cnt = 2; drops = 0; done = 1'b0;
    exp_drops = (act == 2) ? 1 : 0;
    for (int c = 0; c < 40000 && !done; c++) begin
      drop_chk = 1'b0;
      if (cnt == act_cyc) begin
        if (act == 1) i_baud_div = 16'd20;
        if (act == 2) begin i_trig = 1'b1; drop_chk = 1'b1; end
        if (act == 3) begin
          i_valid = 1'b1; i_x = 32'hFFFFFFFF; i_p = $urandom();
          mx = i_x; mp = i_p;
        end
        if (act == 4) begin
          rst_n = 1'b0;
          #1;
          chk("reset_tx_async", o_tx, 1);
          chk("reset_busy_async", o_busy, 0);
          sbq.delete();
          mx = 32'd0; mp = 32'd0;
          repeat (3) @(posedge clk);
          #1 rst_n = 1'b1;
          return;
        end
      end
      @(posedge clk); #1;
      i_trig = 1'b0; i_valid = 1'b0;
      if (drop_chk) chk("drop_pulse", o_drop, 1);
      if (o_drop) drops++;
      if (!o_busy) done = 1'b1;
      else cnt++;
    end
    chk("busy_fell_in_time", done, 1);
    chk("drop_count", drops, exp_drops);
    chk("busy_cycles", cnt, 1 + NB * 10 * per);
    chk("all_bytes_seen", sbq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_x = 32'd0; i_p = 32'd0; i_valid = 1'b0; i_trig = 1'b0;
    i_baud_div = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", o_tx, 1);
    chk("reset_busy", o_busy, 0);
    chk("reset_drop", o_drop, 0);
    rst_n = 1'b1;

    // Reference vector at 10 clocks per bit
    pulse_valid(32'h12345678, 32'h00001F40);
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 0, -1);

    // Minimum divider clamp, mid-frame change deferred to next frame
    i_baud_div = 16'd0;
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 1, 30);
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 0, -1);
    i_baud_div = 16'd9;

    // Ignored trigger, then a mid-frame valid picked up by the next frame
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 2, 50);
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 3, 80);
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 0, -1);

    // Valid and trigger on the same clock
    run_frame(1'b0, 1'b1, 32'hA5A5A5A5, $urandom(), 0, -1);

    // Reset during byte index 2 data bits, then a fresh frame of zeros
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 4, 2 + 21 * 10 + 35);
    chk("after_reset_busy", o_busy, 0);
    run_frame(1'b0, 1'b0, 32'd0, 32'd0, 0, -1);

    // Trigger on the very cycle busy drops
    run_frame(1'b1, 1'b1, 32'hDEADBEEF, 32'h0BADF00D, 0, -1);

    // Randomised frames
    for (int k = 0; k < 5; k++) begin
      i_baud_div = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) pulse_valid($urandom(), $urandom());
      run_frame(1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom(), 0, -1);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
